instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit.sv | 116 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational instruction
// memory, and queues {pc, instruction} pairs in a small FIFO. The head of the
// FIFO goes to the decoder.
//
// Handshake: the head entry is transferred on a rising clock edge where
// outValid && outReady are both 1. outValid does not depend combinationally
// on outReady, and the outputs change only after a clock edge.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    BUF_DEPTH   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  readAddress,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   branchTaken,
  input  logic [ADDR_WIDTH-1:0]  branchTarget,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [INSTR_WIDTH-1:0] outInstruction,
  output logic [ADDR_WIDTH-1:0]  outPC,
  output logic                   misaligned
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [CW-1:0]          r_count;
  logic [PW-1:0]          r_rd_ptr;
  logic [PW-1:0]          r_wr_ptr;
  logic                   r_misaligned;
  logic [ADDR_WIDTH-1:0]  r_out_pc;
  logic [INSTR_WIDTH-1:0] r_out_instr;
  logic [ADDR_WIDTH-1:0]  r_buf_pc    [BUF_DEPTH];
  logic [INSTR_WIDTH-1:0] r_buf_instr [BUF_DEPTH];

  logic                   w_pop;
  logic                   w_push;
  logic                   w_stall_full;
  logic [CW-1:0]          w_count_after_pop;
  logic [CW-1:0]          w_count_next;
  logic [PW-1:0]          w_rd_next;
  logic [ADDR_WIDTH-1:0]  w_head_pc;
  logic [INSTR_WIDTH-1:0] w_head_instr;

  assign readAddress    = r_pc;
  assign outValid       = (r_count != '0);
  assign outPC          = r_out_pc;
  assign outInstruction = r_out_instr;
  assign misaligned     = r_misaligned;

  // Pop, push and the occupancy that results from them. A redirect flushes
  // the buffer, but a head accepted in the same cycle still counts as consumed.
  always_comb begin
    w_pop             = outValid && outReady;
    w_stall_full      = (r_count == CW'(BUF_DEPTH)) && !w_pop;
    w_push            = !branchTaken && !w_stall_full;
    w_count_after_pop = r_count - CW'(w_pop);
    w_rd_next         = r_rd_ptr + PW'(w_pop);
    w_count_next      = branchTaken ? '0 : (w_count_after_pop + CW'(w_push));
  end

  // Select the entry that will be at the head after this edge. If the buffer
  // drains this cycle, the head is the word being fetched now.
  always_comb begin
    w_head_pc    = r_buf_pc[w_rd_next];
    w_head_instr = r_buf_instr[w_rd_next];
    if (w_count_after_pop == '0) begin
      w_head_pc    = r_pc;
      w_head_instr = instruction;
    end
  end

  // PC, pointers, occupancy, the sticky misaligned flag and the head output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_misaligned <= 1'b0;
      r_out_pc     <= '0;
      r_out_instr  <= '0;
    end else begin
      r_count <= w_count_next;
      if (branchTaken) begin
        r_pc         <= {branchTarget[ADDR_WIDTH-1:2], 2'b00};
        r_rd_ptr     <= '0;
        r_wr_ptr     <= '0;
        r_misaligned <= r_misaligned | (branchTarget[1:0] != 2'b00);
      end else begin
        r_rd_ptr <= w_rd_next;
        if (w_push) begin
          r_pc     <= r_pc + ADDR_WIDTH'(4);
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
      end
      if (w_count_next != '0) begin
        r_out_pc    <= w_head_pc;
        r_out_instr <= w_head_instr;
      end
    end
  end

  // Buffer storage. It needs no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_buf_pc[r_wr_ptr]    <= r_pc;
      r_buf_instr[r_wr_ptr] <= instruction;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit. It uses a behavioural instruction memory
// and an expected queue of {pc, instruction} pairs. A second instance starts
// at the top of the address space to exercise PC wrap-around.
module tb_instruction_fetch_unit;

  localparam int AW = 64;
  localparam int IW = 32;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [AW-1:0] readAddress, branchTarget, outPC;
  logic [IW-1:0] instruction, outInstruction;
  logic          branchTaken, outValid, outReady, misaligned;

  logic [AW-1:0] wr_readAddress, wr_outPC;
  logic [IW-1:0] wr_instruction, wr_outInstruction;
  logic          wr_outValid, wr_misaligned;

  int errors = 0;
  int checks = 0;
  logic [AW+IW-1:0] exp_q[$];
  logic [AW+IW-1:0] exp;

  instruction_fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(64'h0), .BUF_DEPTH(2)) u_dut (
    .clock(clock), .reset(reset), .readAddress(readAddress), .instruction(instruction),
    .branchTaken(branchTaken), .branchTarget(branchTarget), .outValid(outValid),
    .outReady(outReady), .outInstruction(outInstruction), .outPC(outPC), .misaligned(misaligned)
  );

  instruction_fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .BUF_DEPTH(2)) u_wrap (
    .clock(clock), .reset(reset), .readAddress(wr_readAddress), .instruction(wr_instruction),
    .branchTaken(1'b0), .branchTarget(64'h0), .outValid(wr_outValid),
    .outReady(1'b1), .outInstruction(wr_outInstruction), .outPC(wr_outPC), .misaligned(wr_misaligned)
  );

  // behavioural memory
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    case (a)
      64'h0:   mem_word = 32'h8B1F03E5;
      64'h4:   mem_word = 32'hF84000A4;
      64'h8:   mem_word = 32'h8B040086;
      64'hC:   mem_word = 32'hF80010A6;
      default: mem_word = a[31:0] ^ 32'h9E37_79B9 ^ {a[15:0], a[31:16]} ^ {a[63:48], a[47:32]};
    endcase
  endfunction

  always_comb instruction    = mem_word(readAddress);
  always_comb wr_instruction = mem_word(wr_readAddress);

  // driver tasks
  task automatic push_exp(input logic [AW-1:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic do_reset(input logic ready);
    @(negedge clock);
    reset = 1'b1; branchTaken = 1'b0; branchTarget = '0; outReady = ready;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", outValid); end
    checks++; if (outPC !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", outPC); end
    checks++; if (outInstruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", outInstruction); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", misaligned); end
    checks++; if (readAddress !== 64'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", readAddress); end
  endtask

  // stream four words back to back straight out of reset
  task automatic test_stream();
    for (int i = 0; i < 4; i++) push_exp(64'(4 * i));
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      exp = exp_q.pop_front();
      checks++;
      if (outValid !== 1'b1 || {outPC, outInstruction} !== exp)
        begin errors++; $display("FAIL stream_%0d: got v=%b %h expected v=1 %h", i, outValid, {outPC, outInstruction}, exp); end
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (outValid !== 1'b1 || outPC !== 64'h0)
        begin errors++; $display("FAIL stall_head_%0d: got v=%b pc=%h expected v=1 pc=0", i, outValid, outPC); end
    end
    checks++; if (readAddress !== 64'h8) begin errors++; $display("FAIL stall_addr: got %h expected 8", readAddress); end
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(64'(4 * i));
    for (int i = 0; i < 3; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (outValid !== 1'b1 || {outPC, outInstruction} !== exp)
        begin errors++; $display("FAIL stall_release_%0d: got v=%b %h expected %h", i, outValid, {outPC, outInstruction}, exp); end
      @(negedge clock);
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (3) @(negedge clock);
    checks++; if (readAddress !== 64'h8) begin errors++; $display("FAIL redir_full_addr: got %h expected 8", readAddress); end
    branchTaken = 1'b1; branchTarget = 64'h40;
    @(negedge clock);
    branchTaken = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b expected 0", outValid); end
    checks++; if (readAddress !== 64'h40) begin errors++; $display("FAIL redir_addr: got %h expected 40", readAddress); end
    outReady = 1'b1;
    @(negedge clock);
    push_exp(64'h40); push_exp(64'h44); push_exp(64'h48);
    for (int i = 0; i < 2; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (outValid !== 1'b1 || {outPC, outInstruction} !== exp)
        begin errors++; $display("FAIL redir_target_%0d: got v=%b %h expected %h", i, outValid, {outPC, outInstruction}, exp); end
      @(negedge clock);
    end
  endtask

  task automatic test_misaligned();
    // head 0x48 is accepted in the same cycle as the redirect
    exp = exp_q.pop_front();
    checks++;
    if (outValid !== 1'b1 || {outPC, outInstruction} !== exp)
      begin errors++; $display("FAIL mis_pop_head: got v=%b %h expected %h", outValid, {outPC, outInstruction}, exp); end
    branchTaken = 1'b1; branchTarget = 64'h42;
    @(negedge clock);
    branchTaken = 1'b0;
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", misaligned); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL mis_flush: got %b expected 0", outValid); end
    checks++; if (readAddress !== 64'h40) begin errors++; $display("FAIL mis_addr: got %h expected 40", readAddress); end
    @(negedge clock);
    push_exp(64'h40); push_exp(64'h44);
    for (int i = 0; i < 2; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (outValid !== 1'b1 || {outPC, outInstruction} !== exp)
        begin errors++; $display("FAIL mis_resume_%0d: got v=%b %h expected %h", i, outValid, {outPC, outInstruction}, exp); end
      @(negedge clock);
    end
    outReady = 1'b0; branchTaken = 1'b1; branchTarget = 64'h80;
    @(negedge clock);
    branchTaken = 1'b0;
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b expected 1", misaligned); end
    @(negedge clock);
    push_exp(64'h80);
    exp = exp_q.pop_front();
    checks++;
    if (outValid !== 1'b1 || {outPC, outInstruction} !== exp)
      begin errors++; $display("FAIL mis_aligned_target: got v=%b %h expected %h", outValid, {outPC, outInstruction}, exp); end
  endtask

  task automatic test_reset_midop();
    outReady = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL midop_pre_valid: got %b expected 1", outValid); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL midop_valid: got %b expected 0", outValid); end
    checks++; if (readAddress !== 64'h0) begin errors++; $display("FAIL midop_addr: got %h expected 0", readAddress); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL midop_misaligned: got %b expected 0", misaligned); end
    checks++; if (outPC !== 64'h0) begin errors++; $display("FAIL midop_pc: got %h expected 0", outPC); end
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) push_exp(64'(4 * i));
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      outReady = 1'($urandom_range(0, 1));
      if (outValid === 1'b1 && outReady) begin
        exp = exp_q.pop_front();
        checks++;
        if ({outPC, outInstruction} !== exp)
          begin errors++; $display("FAIL b2b_cycle_%0d: got %h expected %h", cyc, {outPC, outInstruction}, exp); end
      end
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_timeout: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] wexp [3];
    wexp[0] = 64'hFFFF_FFFF_FFFF_FFFC; wexp[1] = 64'h0; wexp[2] = 64'h4;
    do_reset(1'b1);
    checks++; if (wr_readAddress !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_reset_addr: got %h expected fffffffffffffffc", wr_readAddress); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (wr_outValid !== 1'b1 || wr_outPC !== wexp[i] || wr_outInstruction !== mem_word(wexp[i]))
        begin errors++; $display("FAIL wrap_%0d: got v=%b pc=%h i=%h expected pc=%h i=%h", i, wr_outValid, wr_outPC, wr_outInstruction, wexp[i], mem_word(wexp[i])); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    branchTaken = 1'b0; branchTarget = '0; outReady = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_reset_midop();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
